// File: rtl/sound_sample_decimator_pkg.sv
// Shared types and defaults for the sound sample decimator slice.
package sound_sample_decimator_pkg;

  localparam int unsigned SAMPLE_W       = 20;
  localparam int unsigned DEF_WIN_LOG2   = 6;
  localparam int unsigned DEF_FIFO_DEPTH = 4;

  // One averaged stereo pair as stored in the FIFO.
  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } stereo_sample_t;

  // Occupancy width: must be able to represent a completely full FIFO.
  function automatic int unsigned level_w(input int unsigned depth);
    return int'($clog2(depth)) + 1;
  endfunction

endpackage

// File: rtl/sound_sample_decimator_if.sv
// Mixer-side samples in, AC97-side pair out, plus FIFO status.
interface sound_sample_decimator_if
  import sound_sample_decimator_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) ();

  localparam int unsigned LEVEL_W = level_w(FIFO_DEPTH);

  logic [SAMPLE_W-1:0] so1;
  logic [SAMPLE_W-1:0] so2;
  logic                sample_en;
  logic                pop;
  logic                clr_flags;
  logic [SAMPLE_W-1:0] left_sample;
  logic [SAMPLE_W-1:0] right_sample;
  logic [LEVEL_W-1:0]  level;
  logic                underflow;
  logic                overflow;

  modport master (
    output so1, so2, sample_en, pop, clr_flags,
    input  left_sample, right_sample, level, underflow, overflow
  );

  modport slave (
    input  so1, so2, sample_en, pop, clr_flags,
    output left_sample, right_sample, level, underflow, overflow
  );

endinterface

// File: rtl/sound_sample_decimator_fifo.sv
// Single-clock stereo-pair FIFO; a pop on a full FIFO frees room for a same-cycle push.
module sound_sample_decimator_fifo
  import sound_sample_decimator_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      push,
  input  stereo_sample_t            push_data,
  input  logic                      pop,
  output stereo_sample_t            head_c,
  output logic                      full_c,
  output logic                      empty_c,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = AW + 1;

  stereo_sample_t mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic           push_ok_c;
  logic           pop_ok_c;

  // Status and accept decisions from pre-edge occupancy.
  always_comb begin
    empty_c   = (level == '0);
    full_c    = (level == LEVEL_W'(DEPTH));
    pop_ok_c  = pop && !empty_c;
    push_ok_c = push && (!full_c || pop_ok_c);
    head_c    = mem[rd_ptr];
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push_ok_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok_c, pop_ok_c})
        2'b10:   level <= level + LEVEL_W'(1);
        2'b01:   level <= level - LEVEL_W'(1);
        default: level <= level;
      endcase
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push_ok_c) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/sound_sample_decimator.sv
// Box-car averages SO1/SO2 over 2^WIN_LOG2 enabled samples and buffers pairs for AC97.
module sound_sample_decimator
  import sound_sample_decimator_pkg::*;
#(
  parameter int unsigned WIN_LOG2   = DEF_WIN_LOG2,
  parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst,
  sound_sample_decimator_if.slave   bus
);

  localparam int unsigned ACC_W = SAMPLE_W + WIN_LOG2;

  logic [ACC_W-1:0]    acc_l;
  logic [ACC_W-1:0]    acc_r;
  logic [WIN_LOG2-1:0] win_cnt;
  logic [ACC_W-1:0]    sum_l_c;
  logic [ACC_W-1:0]    sum_r_c;
  logic                win_close_c;
  logic                push_req;
  stereo_sample_t      push_data;
  stereo_sample_t      head_c;
  logic                fifo_full_c;
  logic                fifo_empty_c;
  logic                pop_ok_c;
  logic                under_evt_c;
  logic                over_evt_c;

  // Running sums including this cycle's sample, so the closing sample is never lost.
  always_comb begin
    sum_l_c     = acc_l + ACC_W'(bus.so2);
    sum_r_c     = acc_r + ACC_W'(bus.so1);
    win_close_c = bus.sample_en && (win_cnt == {WIN_LOG2{1'b1}});
  end

  // Accumulate enabled samples; restart from zero when the window closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_l   <= '0;
      acc_r   <= '0;
      win_cnt <= '0;
    end else if (bus.sample_en) begin
      win_cnt <= win_cnt + WIN_LOG2'(1);
      if (win_close_c) begin
        acc_l <= '0;
        acc_r <= '0;
      end else begin
        acc_l <= sum_l_c;
        acc_r <= sum_r_c;
      end
    end
  end

  // Register the truncated average; it is written into the FIFO on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      push_req  <= 1'b0;
      push_data <= '0;
    end else begin
      push_req <= win_close_c;
      if (win_close_c) begin
        push_data.left  <= SAMPLE_W'(sum_l_c >> WIN_LOG2);
        push_data.right <= SAMPLE_W'(sum_r_c >> WIN_LOG2);
      end
    end
  end

  sound_sample_decimator_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push_req),
    .push_data (push_data),
    .pop       (bus.pop),
    .head_c    (head_c),
    .full_c    (fifo_full_c),
    .empty_c   (fifo_empty_c),
    .level     (bus.level)
  );

  // Pop judged on pre-edge contents; overflow only when no pop makes room.
  always_comb begin
    pop_ok_c    = bus.pop && !fifo_empty_c;
    under_evt_c = bus.pop && fifo_empty_c;
    over_evt_c  = push_req && fifo_full_c && !pop_ok_c;
  end

  // AC97 output pair: loads the head on a successful pop, otherwise holds.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.left_sample  <= '0;
      bus.right_sample <= '0;
    end else if (pop_ok_c) begin
      bus.left_sample  <= head_c.left;
      bus.right_sample <= head_c.right;
    end
  end

  // Sticky flags; a new event beats a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.underflow <= 1'b0;
      bus.overflow  <= 1'b0;
    end else begin
      bus.underflow <= under_evt_c || (bus.underflow && !bus.clr_flags);
      bus.overflow  <= over_evt_c  || (bus.overflow  && !bus.clr_flags);
    end
  end

endmodule
